// File: rtl/mac_dot_issuer_if.sv
// mac_dot_issuer_if: command, operand, MAC-side and result signals of the dot-product issuer
interface mac_dot_issuer_if #(parameter int LEN_W = 12);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             mac_ivalid;
  logic             mac_control;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic             mac_ovalid;
  logic [31:0]      mac_dataout;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             err_timeout;
  logic             busy;
  modport master (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, mac_ovalid, mac_dataout, res_ready,
    output cmd_ready, op_ready, mac_ivalid, mac_control, mac_a, mac_b, res_valid, res_data,
           err_timeout, busy
  );
  modport slave (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, mac_ovalid, mac_dataout, res_ready,
    input  cmd_ready, op_ready, mac_ivalid, mac_control, mac_a, mac_b, res_valid, res_data,
           err_timeout, busy
  );
endinterface

// File: rtl/mac_dot_issuer.sv
// mac_dot_issuer: issues dot-product operand pairs to an accumulating FP MAC, one element in flight
module mac_dot_issuer #(
  parameter int MAC_LAT = 9,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic resetn,
  mac_dot_issuer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
  localparam int WD_W = $clog2((TIMEOUT > MAC_LAT ? TIMEOUT : MAC_LAT) + 1);
  state_t           state, state_nx;
  logic [LEN_W-1:0] n, idx;
  logic [WD_W-1:0]  wd;
  logic             last, expired;
  assign last    = idx == n - 1'b1;
  assign expired = wd == WD_W'(TIMEOUT - 1);
  assign bus.cmd_ready   = resetn && state == IDLE;
  assign bus.op_ready    = state == FETCH;
  assign bus.mac_ivalid  = state == ISSUE;
  assign bus.mac_control = state == ISSUE && idx == '0;
  assign bus.res_valid   = state == DONE;
  assign bus.busy        = state != IDLE;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.cmd_valid ? (bus.cmd_len == '0 ? DONE : FETCH) : IDLE;
      FETCH:   state_nx = bus.op_valid ? ISSUE : FETCH;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = bus.mac_ovalid ? (last ? DONE : FETCH) : (expired ? DONE : WAIT);
      DONE:    state_nx = bus.res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      n               <= '0;
      idx             <= '0;
      wd              <= '0;
      bus.mac_a       <= '0;
      bus.mac_b       <= '0;
      bus.res_data    <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          n               <= bus.cmd_len;
          idx             <= '0;
          bus.err_timeout <= 1'b0;
          bus.res_data    <= '0;
        end
        FETCH: if (bus.op_valid) begin
          bus.mac_a <= bus.op_a;
          bus.mac_b <= bus.op_b;
        end
        ISSUE: wd <= '0;
        WAIT: begin
          wd <= wd + 1'b1;
          if (bus.mac_ovalid) begin
            if (last) bus.res_data <= bus.mac_dataout;
            else idx <= idx + 1'b1;
          end else if (expired) begin
            bus.err_timeout <= 1'b1;
            bus.res_data    <= 32'h7FC0_0000;
          end
        end
        default: ;
      endcase
    end
endmodule
